// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module   : battleship_pkg
// Purpose  : Board geometry, result codes, FSM encoding and cell helpers for
//            the 5x7 battleship attack stage.
// Revision : 1.0
// ============================================================================
package battleship_pkg;

  localparam int NUM_COLS  = 5;
  localparam int NUM_ROWS  = 7;
  localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_MISS   = 2'b01,
    RES_HIT    = 2'b10,
    RES_REPEAT = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [5:0] popcount_cells(input logic [NUM_CELLS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Cells are stored column-major: bit index = col*NUM_ROWS + row.
  function automatic logic [5:0] cell_index(input logic [2:0] col, input logic [2:0] row);
    return 6'(col) * 6'(NUM_ROWS) + 6'(row);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : button_edge_detect
// Purpose  : Rising-edge pulse from a debounced level; a held level yields one pulse.
// Revision : 1.0
// ============================================================================
module button_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule
`default_nettype wire

// File: rtl/attack_controller.sv
`default_nettype none
// ============================================================================
// Module   : attack_controller
// Purpose  : Attack-mode stage: evaluates shots against the latched fleet layout
//            and drives hit/shot maps, score and game-over status.
//            Optional: ATTACK_REPEAT_PENALTY_EN makes repeated valid cells cost a shot.
// Revision : 1.0
// ============================================================================
module attack_controller
  import battleship_pkg::*;
#(
  parameter int MAX_SHOTS  = 20,
  parameter int SHOT_CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  game_start,
  input  logic                  attack_button,
  input  logic [2:0]            columns_attack,
  input  logic [2:0]            rows_attack,
  input  logic [6:0]            col1_in,
  input  logic [6:0]            col2_in,
  input  logic [6:0]            col3_in,
  input  logic [6:0]            col4_in,
  input  logic [6:0]            col5_in,
  output logic [6:0]            colHit1,
  output logic [6:0]            colHit2,
  output logic [6:0]            colHit3,
  output logic [6:0]            colHit4,
  output logic [6:0]            colHit5,
  output logic [6:0]            colShot1,
  output logic [6:0]            colShot2,
  output logic [6:0]            colShot3,
  output logic [6:0]            colShot4,
  output logic [6:0]            colShot5,
  output logic [SHOT_CNT_W-1:0] shots_count,
  output logic [SHOT_CNT_W-1:0] hits_count,
  output logic [1:0]            last_result,
  output logic                  result_valid,
  output logic                  game_over,
  output logic                  game_won
);

  logic start_pulse;
  logic attack_pulse;

  button_edge_detect u_start_edge (
    .clk   (clk),
    .reset (reset),
    .level (game_start),
    .pulse (start_pulse)
  );

  button_edge_detect u_attack_edge (
    .clk   (clk),
    .reset (reset),
    .level (attack_button),
    .pulse (attack_pulse)
  );

  state_t                state_q;
  logic [NUM_CELLS-1:0]  layout_q;
  logic [NUM_CELLS-1:0]  shot_q;
  logic [NUM_CELLS-1:0]  hit_q;
  logic [5:0]            ship_cells_q;
  logic [SHOT_CNT_W-1:0] shots_q;
  logic [SHOT_CNT_W-1:0] hits_q;
  logic [2:0]            col_q;
  logic [2:0]            row_q;
  result_t               last_result_q;
  logic                  result_valid_q;
  logic                  game_over_q;
  logic                  game_won_q;

  logic [NUM_CELLS-1:0]  layout_in;
  logic [5:0]            ship_cells_d;
  logic [SHOT_CNT_W-1:0] shots_d;
  logic [SHOT_CNT_W-1:0] hits_d;
  logic [5:0]            cell_idx;
  logic                  cell_valid;
  logic                  cell_shot;
  logic                  cell_ship;
  logic                  hits_reach;
  logic                  shot_limit;
  logic                  start_take;

  assign layout_in    = {col5_in, col4_in, col3_in, col2_in, col1_in};
  assign ship_cells_d = popcount_cells(layout_in);
  assign shots_d      = shots_q + SHOT_CNT_W'(1);
  assign hits_d       = hits_q + SHOT_CNT_W'(1);
  assign cell_idx     = cell_index(col_q, row_q);
  assign cell_valid   = (col_q < 3'(NUM_COLS)) && (row_q < 3'(NUM_ROWS));
  // Map lookups are only meaningful for in-range coordinates.
  assign cell_shot    = cell_valid && shot_q[cell_idx];
  assign cell_ship    = cell_valid && layout_q[cell_idx];
  assign hits_reach   = (32'(hits_d) == 32'(ship_cells_q));
  assign shot_limit   = (32'(shots_d) == 32'(MAX_SHOTS));
  assign start_take   = start_pulse && (state_q != ST_EVAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      layout_q       <= '0;
      shot_q         <= '0;
      hit_q          <= '0;
      ship_cells_q   <= '0;
      shots_q        <= '0;
      hits_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      last_result_q  <= RES_NONE;
      result_valid_q <= 1'b0;
      game_over_q    <= 1'b0;
      game_won_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (start_take) begin
        // A start edge outranks a simultaneous attack edge.
        layout_q      <= layout_in;
        ship_cells_q  <= ship_cells_d;
        shot_q        <= '0;
        hit_q         <= '0;
        shots_q       <= '0;
        hits_q        <= '0;
        last_result_q <= RES_NONE;
        game_over_q   <= 1'b0;
        game_won_q    <= 1'b0;
        state_q       <= (ship_cells_d != 6'd0) ? ST_READY : ST_IDLE;
      end else begin
        unique case (state_q)
          ST_READY: begin
            if (attack_pulse) begin
              col_q   <= columns_attack;
              row_q   <= rows_attack;
              state_q <= ST_EVAL;
            end
          end
          ST_EVAL: begin
            result_valid_q <= 1'b1;
            state_q        <= ST_READY;
            if (!cell_valid) begin
              last_result_q <= RES_REPEAT;
            end else if (cell_shot) begin
              last_result_q <= RES_REPEAT;
`ifdef ATTACK_REPEAT_PENALTY_EN
              shots_q <= shots_d;
              if (shot_limit) begin
                state_q     <= ST_DONE;
                game_over_q <= 1'b1;
              end
`endif
            end else begin
              shot_q[cell_idx] <= 1'b1;
              shots_q          <= shots_d;
              if (cell_ship) begin
                hit_q[cell_idx] <= 1'b1;
                hits_q          <= hits_d;
                last_result_q   <= RES_HIT;
              end else begin
                last_result_q   <= RES_MISS;
              end
              if (cell_ship && hits_reach) begin
                state_q     <= ST_DONE;
                game_over_q <= 1'b1;
                game_won_q  <= 1'b1;
              end else if (shot_limit) begin
                state_q     <= ST_DONE;
                game_over_q <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The hit counter must be able to reach ship_cells, otherwise a win is undetectable.
  assert property (@(posedge clk) disable iff (reset)
    !(start_take && (32'(ship_cells_d) >= (32'd1 << SHOT_CNT_W))));

  assign colHit1      = hit_q[6:0];
  assign colHit2      = hit_q[13:7];
  assign colHit3      = hit_q[20:14];
  assign colHit4      = hit_q[27:21];
  assign colHit5      = hit_q[34:28];
  assign colShot1     = shot_q[6:0];
  assign colShot2     = shot_q[13:7];
  assign colShot3     = shot_q[20:14];
  assign colShot4     = shot_q[27:21];
  assign colShot5     = shot_q[34:28];
  assign shots_count  = shots_q;
  assign hits_count   = hits_q;
  assign last_result  = last_result_q;
  assign result_valid = result_valid_q;
  assign game_over    = game_over_q;
  assign game_won     = game_won_q;

endmodule
`default_nettype wire

// File: tb/tb_attack_controller.sv
`default_nettype none
// Bench for attack_controller: directed table, multi-cycle corner sequences and
// randomized play compared against a cell-array game model.
module tb_attack_controller;

  localparam int MAXS = 20;
`ifdef ATTACK_REPEAT_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        game_start;
  logic        attack_button;
  logic [2:0]  columns_attack;
  logic [2:0]  rows_attack;
  logic [34:0] lay_drv;
  logic [6:0]  colHit1, colHit2, colHit3, colHit4, colHit5;
  logic [6:0]  colShot1, colShot2, colShot3, colShot4, colShot5;
  logic [4:0]  shots_count, hits_count;
  logic [1:0]  last_result;
  logic        result_valid, game_over, game_won;
  logic [34:0] hit_act, shot_act;

  attack_controller #(.MAX_SHOTS(MAXS), .SHOT_CNT_W(5)) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .attack_button(attack_button),
    .columns_attack(columns_attack), .rows_attack(rows_attack),
    .col1_in(lay_drv[6:0]), .col2_in(lay_drv[13:7]), .col3_in(lay_drv[20:14]),
    .col4_in(lay_drv[27:21]), .col5_in(lay_drv[34:28]),
    .colHit1(colHit1), .colHit2(colHit2), .colHit3(colHit3), .colHit4(colHit4), .colHit5(colHit5),
    .colShot1(colShot1), .colShot2(colShot2), .colShot3(colShot3), .colShot4(colShot4), .colShot5(colShot5),
    .shots_count(shots_count), .hits_count(hits_count), .last_result(last_result),
    .result_valid(result_valid), .game_over(game_over), .game_won(game_won)
  );

  assign hit_act  = {colHit5, colHit4, colHit3, colHit2, colHit1};
  assign shot_act = {colShot5, colShot4, colShot3, colShot2, colShot1};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Game model: plain per-cell bookkeeping of the rules.
  logic [34:0] m_lay, m_shot, m_hit;
  int m_shots, m_hits, m_ship, m_last;
  bit m_ready, m_over, m_won;

  function automatic void m_reset();
    m_lay = '0; m_shot = '0; m_hit = '0;
    m_shots = 0; m_hits = 0; m_ship = 0; m_last = 0;
    m_ready = 0; m_over = 0; m_won = 0;
  endfunction

  function automatic void m_start(input logic [34:0] lay);
    m_lay = lay; m_ship = $countones(lay);
    m_shot = '0; m_hit = '0; m_shots = 0; m_hits = 0; m_last = 0;
    m_over = 0; m_won = 0; m_ready = (m_ship != 0);
  endfunction

  function automatic bit m_attack(input int c, input int r);
    int i;
    if (!m_ready || m_over) return 1'b0;
    if (c > 4 || r > 6) begin
      m_last = 3;
    end else begin
      i = c * 7 + r;
      if (m_shot[i]) begin
        m_last = 3;
        if (PEN) m_shots++;
      end else begin
        m_shot[i] = 1'b1;
        m_shots++;
        if (m_lay[i]) begin
          m_hit[i] = 1'b1; m_hits++; m_last = 2;
        end else begin
          m_last = 1;
        end
      end
    end
    if (m_hits == m_ship) begin
      m_over = 1; m_won = 1;
    end else if (m_shots == MAXS) begin
      m_over = 1;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " hitmap"},  64'(hit_act),      64'(m_hit));
    chk({tag, " shotmap"}, 64'(shot_act),     64'(m_shot));
    chk({tag, " shots"},   64'(shots_count),  64'(m_shots));
    chk({tag, " hits"},    64'(hits_count),   64'(m_hits));
    chk({tag, " result"},  64'(last_result),  64'(m_last));
    chk({tag, " over"},    64'(game_over),    64'(m_over));
    chk({tag, " won"},     64'(game_won),     64'(m_won));
  endtask

  task automatic press(input int c, input int r, output logic rv0, output logic rv1, output logic rv2);
    columns_attack = 3'(c); rows_attack = 3'(r); attack_button = 1'b1;
    @(negedge clk); rv0 = result_valid;
    @(negedge clk); rv1 = result_valid;
    attack_button = 1'b0;
    @(negedge clk); rv2 = result_valid;
  endtask

  task automatic fire(input int c, input int r, input string tag);
    logic rv0, rv1, rv2;
    bit exp_v;
    exp_v = m_attack(c, r);
    press(c, r, rv0, rv1, rv2);
    chk({tag, " rv_early"}, 64'(rv0), 64'(0));
    chk({tag, " rv_pulse"}, 64'(rv1), 64'(exp_v));
    chk({tag, " rv_after"}, 64'(rv2), 64'(0));
    chk_model(tag);
  endtask

  task automatic start_round(input logic [34:0] lay);
    lay_drv = lay; game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    m_start(lay);
    @(negedge clk);
  endtask

  typedef struct {
    int c; int r; int res; int shots_off; int shots_on; int hits;
    bit over; bit won; logic [6:0] hit1; logic [6:0] shot3;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic rv0, rv1, rv2;
    int pulses;
    logic [34:0] lay;

    tbl[0] = '{0, 0, 2, 1, 1, 1, 0, 0, 7'b0000001, 7'b0000000};
    tbl[1] = '{2, 3, 1, 2, 2, 1, 0, 0, 7'b0000001, 7'b0001000};
    tbl[2] = '{0, 0, 3, 2, 3, 1, 0, 0, 7'b0000001, 7'b0001000};
    tbl[3] = '{5, 2, 3, 2, 3, 1, 0, 0, 7'b0000001, 7'b0001000};
    tbl[4] = '{0, 1, 2, 3, 4, 2, 0, 0, 7'b0000011, 7'b0001000};
    tbl[5] = '{0, 2, 2, 4, 5, 3, 1, 1, 7'b0000111, 7'b0001000};

    reset = 1'b1; game_start = 1'b0; attack_button = 1'b0;
    columns_attack = '0; rows_attack = '0; lay_drv = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset rv", 64'(result_valid), 64'(0));
    chk_model("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed table on the three-cell vertical ship in column 0.
    start_round(35'h7);
    chk_model("start1");
    for (int i = 0; i < 6; i++) begin
      bit ev;
      ev = m_attack(tbl[i].c, tbl[i].r);
      press(tbl[i].c, tbl[i].r, rv0, rv1, rv2);
      chk("tbl rv_early", 64'(rv0), 64'(0));
      chk("tbl rv_pulse", 64'(rv1), 64'(1));
      chk("tbl rv_after", 64'(rv2), 64'(0));
      chk("tbl result", 64'(last_result), 64'(tbl[i].res));
      chk("tbl shots", 64'(shots_count), 64'(PEN ? tbl[i].shots_on : tbl[i].shots_off));
      chk("tbl hits", 64'(hits_count), 64'(tbl[i].hits));
      chk("tbl over", 64'(game_over), 64'(tbl[i].over));
      chk("tbl won", 64'(game_won), 64'(tbl[i].won));
      chk("tbl colHit1", 64'(colHit1), 64'(tbl[i].hit1));
      chk("tbl colShot3", 64'(colShot3), 64'(tbl[i].shot3));
      chk("tbl colHit3", 64'(colHit3), 64'(0));
      chk("tbl model_valid", 64'(ev), 64'(1));
      chk_model("tbl");
    end
    fire(1, 1, "done_frozen");
    fire(4, 6, "done_frozen2");

    // A held attack button fires exactly once.
    start_round(35'h7);
    columns_attack = 3'd3; rows_attack = 3'd3; attack_button = 1'b1;
    void'(m_attack(3, 3));
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    attack_button = 1'b0;
    @(negedge clk);
    chk("hold pulses", 64'(pulses), 64'(1));
    chk_model("hold");

    // Start and attack edges together: start wins, attack dropped.
    lay_drv = 35'h1 << 7; columns_attack = 3'd0; rows_attack = 3'd0;
    game_start = 1'b1; attack_button = 1'b1;
    @(negedge clk);
    m_start(35'h1 << 7);
    game_start = 1'b0; attack_button = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    chk("start_wins pulses", 64'(pulses), 64'(0));
    chk_model("start_wins");

    // Mid-round layout change is ignored; the latched single ship at (1,0) wins.
    lay_drv = '0;
    fire(1, 0, "midchange");
    chk("midchange won", 64'(game_won), 64'(1));

    // Loss after MAX_SHOTS misses on a single-cell layout.
    start_round(35'h1 << 34);
    for (int k = 0; k < MAXS; k++) begin
      fire(k / 7, k % 7, "loss");
    end
    chk("loss over", 64'(game_over), 64'(1));
    chk("loss won", 64'(game_won), 64'(0));
    start_round(35'h1 << 34);
    chk("restart over", 64'(game_over), 64'(0));
    chk("restart shots", 64'(shots_count), 64'(0));
    fire(4, 6, "restart_win");

    // Asynchronous reset while in EVAL.
    start_round(35'h7 << 14);
    fire(0, 0, "pre_reset");
    columns_attack = 3'd2; rows_attack = 3'd2; attack_button = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async hitmap", 64'(hit_act), 64'(0));
    chk("async shotmap", 64'(shot_act), 64'(0));
    chk("async shots", 64'(shots_count), 64'(0));
    chk("async result", 64'(last_result), 64'(0));
    chk("async rv", 64'(result_valid), 64'(0));
    attack_button = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    chk("post_reset rv", 64'(result_valid), 64'(0));
    chk_model("post_reset");

    // All-zero layout keeps the game idle.
    start_round('0);
    chk_model("zero_layout");
    fire(0, 0, "zero_idle");

    // Randomized play against the model.
    for (int rnd = 0; rnd < 8; rnd++) begin
      lay = '0;
      for (int i = 0; i < 35; i++) lay[i] = ($urandom_range(0, 3) == 0);
      if ($countones(lay) >= 32) lay[34:20] = '0;
      start_round(lay);
      for (int s = 0; s < 30; s++) begin
        int c, r, idx, st;
        if ($urandom_range(0, 39) == 0) begin
          lay = '0;
          for (int i = 0; i < 35; i++) lay[i] = ($urandom_range(0, 3) == 0);
          if ($countones(lay) >= 32) lay[34:20] = '0;
          start_round(lay);
        end
        c = $urandom_range(0, 5); r = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) begin
          st = $urandom_range(0, 34); idx = -1;
          for (int k = 0; k < 35; k++) begin
            if (idx < 0 && m_lay[(st + k) % 35]) idx = (st + k) % 35;
          end
          if (idx >= 0) begin
            c = idx / 7; r = idx % 7;
          end
        end
        fire(c, r, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
